aes_stream_wrapper: RTL
=======================

# aes_stream_wrapper

Parametrised memory-mapped front end for the AES-128 core that queues multiple key/data commands and buffers multiple ciphertext results. Software stages a 128-bit word and pushes it as a data or key command into a command FIFO. A dispatcher FSM issues the commands to the core in order and captures each ciphertext into a result FIFO, which software then reads and pops. The block sits between the 32-bit bus slave port and the AES core, with status, counters and an optional interrupt.

## Interface
- CMD_DEPTH, 4, command FIFO entries (power of 2, 2..128); each entry is {is_key, 128-bit word}
- RES_DEPTH, 4, result FIFO entries (power of 2, 2..128)
- iClk  in  1  single clock, rising edge
- iReset  in  1  asynchronous, active-high reset; clears all state
- iChipSelect_n  in  1  bus select, active low
- iWrite_n  in  1  write strobe, active low, one cycle per access
- iRead_n  in  1  read strobe, active low
- iAddress  in  4  register address
- iData  in  32  write data
- oData  out  32  registered read data
- oCoreData  out  128  key/plaintext to core, registered
- oCoreLoadKey  out  1  one-cycle key-load pulse
- oCoreLoadData  out  1  one-cycle data-load pulse
- iCoreReady  in  1  core accepts new input
- iCoreValid  in  1  ciphertext valid, one cycle
- iCoreResult  in  128  ciphertext
- oIrq  out  1  level interrupt, registered

## Operation
- Register map. Write = CS&WR low; read = CS&RD low.
  - 0–3 RW: staging words [127:96]..[31:0].
  - 4 W: push data command from staging.
  - 5 W: push key command from staging.
  - 6–9 R: result FIFO head words [127:96]..[31:0]. Reads 0 when empty.
  - 10 W: pop result. 10 R: status. Bit 0 res_not_empty, bit 1 cmd_full, bit 2 cmd_empty, bit 3 res_full, bit 4 busy (FSM≠IDLE), bit 5 cmd_overflow (sticky), bit 6 res_underflow (sticky). Other bits 0.
  - 11 R: {16'd0, res_count[7:0], cmd_count[7:0]}. 11 W: iData[0]=1 clears cmd_overflow, iData[1]=1 clears res_underflow.
  - 12 RW: irq_en[1:0]. Other bits read 0.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Push when cmd FIFO is full:
  - The command is dropped and cmd_overflow is set.
  - This applies even if the dispatcher pops in the same cycle.
- Pop when result FIFO is empty: no change, res_underflow set.
- Dispatcher FSM: IDLE, LOAD, WAIT.
  - IDLE→LOAD when all hold: cmd not empty, iCoreReady=1, and for data commands res_count < RES_DEPTH. On this transition: oCoreData<=head word, cmd popped, type latched.
  - LOAD: asserts oCoreLoadKey or oCoreLoadData for exactly this cycle. Key → IDLE. Data → WAIT.
  - WAIT: on iCoreValid, iCoreResult is pushed into the result FIFO, then →IDLE.
  - iCoreValid outside WAIT is ignored.
- Result slot is guaranteed, so the WAIT push never overflows.
- Commands issue strictly in push order. A key command behind data commands takes effect only after those data commands are issued.
- Simultaneous events:
  - A bus push and a dispatcher pop in the same cycle both take effect.
  - A bus pop and a WAIT push in the same cycle both take effect; count is unchanged.
  - A read and a write to different addresses in the same cycle are both serviced.
- Counts are CMD_DEPTH/RES_DEPTH-sized. Pointers wrap modulo depth. Count fields are zero-extended to 8 bits.

## Timing
- Reset values:
  - oData=0, oCoreData=0, oCoreLoadKey=0, oCoreLoadData=0, oIrq=0.
  - FIFOs empty, staging=0, flags=0, irq_en=0, FSM=IDLE.
- oData updates on the clock edge after the read strobe and holds until the next read.
- Register writes take effect at the strobe edge, so a status read in the next cycle reflects them.
- Command push to core pulse:
  - With FSM idle and iCoreReady=1, a command pushed at edge N produces its load pulse in cycle N+2 (N+1 IDLE→LOAD, N+2 LOAD).
  - oCoreData is stable from N+1 onward.
- iCoreValid at edge M: result is visible at addresses 6–9 to a read strobe in cycle M+1, with oData at M+2.
- Reset mid-operation clears everything, including any in-flight command; a late iCoreValid after reset is ignored. The core itself is not reset by this block.

## Configuration
- AES_WRAP_IRQ_EN defined:
  - oIrq is registered as (irq_en[0] & res_not_empty) | (irq_en[1] & (cmd_overflow | res_underflow)).
  - Address 12 is implemented.
- Not defined:
  - oIrq is tied 0.
  - Address 12 reads 0 and ignores writes.
  - No irq_en storage.

## Test plan
- Reset, then read addresses 10 and 11 → status 0x4 (cmd_empty only), counts 0; all outputs 0.
- Stage 0x2b7e1516_28aed2a6_abf71588_09cf4f3c and push key (addr 5); with core model ready → one oCoreLoadKey pulse, oCoreData equals the staged word, status busy clears.
- Push three data commands with a model that returns plaintext XOR 0xFF..FF after 10 cycles:
  - Three results are read in order from 6–9 with pop between.
  - res_count goes 3→0.
- RES_DEPTH=4: fill the result FIFO without popping and push a 5th data command → no oCoreLoadData issued until one pop, then it issues.
- CMD_DEPTH=4 with iCoreReady=0: push 5 → cmd_count=4, cmd_overflow=1. Write 0x1 to 11 → flag clears. Pop with empty result FIFO → res_underflow=1.
- With AES_WRAP_IRQ_EN and irq_en=1:
  - oIrq rises the cycle after the first result is pushed and falls after the last pop.
  - Assert iReset during WAIT → all cleared, the subsequent iCoreValid is ignored.

Source files
------------

// File: rtl/aes_stream_wrapper.sv
// rtl/aes_stream_wrapper.sv - Bus front end that queues AES key/data commands and buffers ciphertext results
// Define AES_WRAP_IRQ_EN to build the interrupt output and the irq_en register at address 12.
module aes_stream_wrapper #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic         iClk,
    input  logic         iReset,
    input  logic         iChipSelect_n,
    input  logic         iWrite_n,
    input  logic         iRead_n,
    input  logic [3:0]   iAddress,
    input  logic [31:0]  iData,
    output logic [31:0]  oData,
    output logic [127:0] oCoreData,
    output logic         oCoreLoadKey,
    output logic         oCoreLoadData,
    input  logic         iCoreReady,
    input  logic         iCoreValid,
    input  logic [127:0] iCoreResult,
    output logic         oIrq
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0] CMD_MAX = (CAW+1)'(CMD_DEPTH);
    localparam logic [RAW:0] RES_MAX = (RAW+1)'(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;
    state_t state_q, state_d;

    logic wr_en, rd_en, push_req, pop_req, clr_req;
    assign wr_en    = ~iChipSelect_n & ~iWrite_n;
    assign rd_en    = ~iChipSelect_n & ~iRead_n;
    assign push_req = wr_en & ((iAddress == 4'd4) | (iAddress == 4'd5));
    assign pop_req  = wr_en & (iAddress == 4'd10);
    assign clr_req  = wr_en & (iAddress == 4'd11);

    logic [127:0] stage_q;
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            stage_q <= '0;
        end else if (wr_en && iAddress[3:2] == 2'b00) begin
            stage_q[{~iAddress[1:0], 5'd0} +: 32] <= iData;
        end
    end

    // Command FIFO entry: {is_key, word}; address 5 (key) has bit 0 set.
    logic [128:0]   cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] cmd_wptr_q, cmd_rptr_q;
    logic [CAW:0]   cmd_cnt_q;
    logic           cmd_full, cmd_empty, cmd_push, cmd_pop;
    logic [128:0]   cmd_head;
    assign cmd_full  = (cmd_cnt_q == CMD_MAX);
    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_push  = push_req & ~cmd_full;
    assign cmd_head  = cmd_mem[cmd_rptr_q];

    always_ff @(posedge iClk) begin
        if (cmd_push) cmd_mem[cmd_wptr_q] <= {iAddress[0], stage_q};
    end

    logic [127:0]   res_mem [RES_DEPTH];
    logic [RAW-1:0] res_wptr_q, res_rptr_q;
    logic [RAW:0]   res_cnt_q;
    logic           res_full, res_empty, res_push, res_pop;
    logic [127:0]   res_word;
    assign res_full  = (res_cnt_q == RES_MAX);
    assign res_empty = (res_cnt_q == '0);
    assign res_pop   = pop_req & ~res_empty;
    assign res_word  = res_empty ? '0 : res_mem[res_rptr_q];

    always_ff @(posedge iClk) begin
        if (res_push) res_mem[res_wptr_q] <= iCoreResult;
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
            res_wptr_q <= '0;
            res_rptr_q <= '0;
            res_cnt_q  <= '0;
        end else begin
            cmd_wptr_q <= cmd_wptr_q + CAW'(cmd_push);
            cmd_rptr_q <= cmd_rptr_q + CAW'(cmd_pop);
            cmd_cnt_q  <= cmd_cnt_q + (CAW+1)'(cmd_push) - (CAW+1)'(cmd_pop);
            res_wptr_q <= res_wptr_q + RAW'(res_push);
            res_rptr_q <= res_rptr_q + RAW'(res_pop);
            res_cnt_q  <= res_cnt_q + (RAW+1)'(res_push) - (RAW+1)'(res_pop);
        end
    end

    // Only one command is ever in flight, so a free result slot at issue time
    // guarantees the WAIT push cannot overflow.
    logic         key_q;
    logic [127:0] core_data_q;
    always_comb begin
        state_d  = state_q;
        cmd_pop  = 1'b0;
        res_push = 1'b0;
        case (state_q)
            S_IDLE: if (!cmd_empty && iCoreReady && (cmd_head[128] || !res_full)) begin
                cmd_pop = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: state_d = key_q ? S_IDLE : S_WAIT;
            S_WAIT: if (iCoreValid) begin
                res_push = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            key_q       <= 1'b0;
            core_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_pop) {key_q, core_data_q} <= cmd_head;
        end
    end

    assign oCoreData     = core_data_q;
    assign oCoreLoadKey  = (state_q == S_LOAD) & key_q;
    assign oCoreLoadData = (state_q == S_LOAD) & ~key_q;

    logic cmd_of_q, res_uf_q;
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            cmd_of_q <= 1'b0;
            res_uf_q <= 1'b0;
        end else begin
            if (push_req && cmd_full)       cmd_of_q <= 1'b1;
            else if (clr_req && iData[0])   cmd_of_q <= 1'b0;
            if (pop_req && res_empty)       res_uf_q <= 1'b1;
            else if (clr_req && iData[1])   res_uf_q <= 1'b0;
        end
    end

`ifdef AES_WRAP_IRQ_EN
    logic [1:0] irq_en_q;
    logic       irq_q;
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            irq_en_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && iAddress == 4'd12) irq_en_q <= iData[1:0];
            irq_q <= (irq_en_q[0] & ~res_empty) | (irq_en_q[1] & (cmd_of_q | res_uf_q));
        end
    end
    assign oIrq = irq_q;
`else
    assign oIrq = 1'b0;
`endif

    logic [31:0] rdata, data_q;
    always_comb begin
        rdata = '0;
        case (iAddress)
            4'd0, 4'd1, 4'd2, 4'd3: rdata = stage_q[{~iAddress[1:0], 5'd0} +: 32];
            4'd6:  rdata = res_word[127:96];
            4'd7:  rdata = res_word[95:64];
            4'd8:  rdata = res_word[63:32];
            4'd9:  rdata = res_word[31:0];
            4'd10: rdata = {25'd0, res_uf_q, cmd_of_q, (state_q != S_IDLE),
                            res_full, cmd_empty, cmd_full, ~res_empty};
            4'd11: rdata = {16'd0, 8'(res_cnt_q), 8'(cmd_cnt_q)};
`ifdef AES_WRAP_IRQ_EN
            4'd12: rdata = {30'd0, irq_en_q};
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset)     data_q <= '0;
        else if (rd_en) data_q <= rdata;
    end
    assign oData = data_q;

endmodule
